vga_ports: RTL and testbench

VGA_PORTS -- requirements
Module: vga_ports

---
 rtl/vga_ports.sv | 229 ++++++++++++++++++++++
 tb/tb_vga_ports.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ports.sv
// VGA I/O port block: DAC palette index/data ports, CRTC cursor registers,
// mode control and the vertical-retrace status flag.
module vga_ports (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] port_a,
   input  logic [7:0]  port_i,
   input  logic        port_w,
   input  logic        port_r,
   output logic [7:0]  port_o,
   output logic        videomode,
   output logic [11:0] cursor,
   output logic [7:0]  dac_a,
   output logic [11:0] dac_d,
   output logic        dac_w,
   input  logic [11:0] dac_q,
   input  logic        vretrace
);

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned COMP_W = 6;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned CRTC_W = 5;
   localparam int unsigned CUR_W  = 12;
   localparam int unsigned PAL_W  = 12;

   localparam logic [ADDR_W-1:0] ADDR_DAC_RIDX = 16'h03C7;
   localparam logic [ADDR_W-1:0] ADDR_DAC_WIDX = 16'h03C8;
   localparam logic [ADDR_W-1:0] ADDR_DAC_DATA = 16'h03C9;
   localparam logic [ADDR_W-1:0] ADDR_CRTC_IDX = 16'h03D4;
   localparam logic [ADDR_W-1:0] ADDR_CRTC_DAT = 16'h03D5;
   localparam logic [ADDR_W-1:0] ADDR_MODE     = 16'h03D8;
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = 16'h03DA;

   localparam logic [CRTC_W-1:0] CRTC_CUR_HI = 5'h0E;
   localparam logic [CRTC_W-1:0] CRTC_CUR_LO = 5'h0F;

   // state registers
   logic [DATA_W-1:0] r_port_o;
   logic              r_videomode;
   logic [CUR_W-1:0]  r_cursor;
   logic [IDX_W-1:0]  r_dac_a;
   logic [PAL_W-1:0]  r_dac_d;
   logic              r_dac_w;
   logic [IDX_W-1:0]  r_windex;
   logic [IDX_W-1:0]  r_rindex;
   logic [CNT_W-1:0]  r_wcnt;
   logic [CNT_W-1:0]  r_rcnt;
   logic [COMP_W-1:0] r_red;
   logic [COMP_W-1:0] r_grn;
   logic [CRTC_W-1:0] r_crtc_idx;
   logic              r_flag;

   // next-state values
   logic [DATA_W-1:0] w_port_o_nxt;
   logic              w_videomode_nxt;
   logic [CUR_W-1:0]  w_cursor_nxt;
   logic [IDX_W-1:0]  w_dac_a_nxt;
   logic [PAL_W-1:0]  w_dac_d_nxt;
   logic              w_dac_w_nxt;
   logic [IDX_W-1:0]  w_windex_nxt;
   logic [IDX_W-1:0]  w_rindex_nxt;
   logic [CNT_W-1:0]  w_wcnt_nxt;
   logic [CNT_W-1:0]  w_rcnt_nxt;
   logic [COMP_W-1:0] w_red_nxt;
   logic [COMP_W-1:0] w_grn_nxt;
   logic [CRTC_W-1:0] w_crtc_idx_nxt;
   logic              w_flag_nxt;

   logic              w_wr;
   logic              w_rd;
   logic [3:0]        w_comp;

   // a write strobe masks a coincident read entirely
   assign w_wr = port_w;
   assign w_rd = port_r & ~port_w;

   // nibble of the palette word selected by the read component counter
   always_comb begin
      w_comp = dac_q[3:0];
      case (r_rcnt)
         2'd0:    w_comp = dac_q[11:8];
         2'd1:    w_comp = dac_q[7:4];
         default: w_comp = dac_q[3:0];
      endcase
   end

   // next-state decode for all port side effects and read data
   always_comb begin
      w_port_o_nxt    = r_port_o;
      w_videomode_nxt = r_videomode;
      w_cursor_nxt    = r_cursor;
      w_dac_d_nxt     = r_dac_d;
      w_dac_w_nxt     = 1'b0;
      w_windex_nxt    = r_windex;
      w_rindex_nxt    = r_rindex;
      w_wcnt_nxt      = r_wcnt;
      w_rcnt_nxt      = r_rcnt;
      w_red_nxt       = r_red;
      w_grn_nxt       = r_grn;
      w_crtc_idx_nxt  = r_crtc_idx;
      w_flag_nxt      = r_flag;
      w_dac_a_nxt     = r_rindex;

      if (w_wr) begin
         case (port_a)
            ADDR_DAC_RIDX: begin
               w_rindex_nxt = port_i;
               w_rcnt_nxt   = 2'd0;
            end
            ADDR_DAC_WIDX: begin
               w_windex_nxt = port_i;
               w_wcnt_nxt   = 2'd0;
            end
            ADDR_DAC_DATA: begin
               case (r_wcnt)
                  2'd0: begin
                     w_red_nxt  = port_i[5:0];
                     w_wcnt_nxt = 2'd1;
                  end
                  2'd1: begin
                     w_grn_nxt  = port_i[5:0];
                     w_wcnt_nxt = 2'd2;
                  end
                  default: begin
                     w_dac_w_nxt  = 1'b1;
                     w_dac_d_nxt  = {r_red[5:2], r_grn[5:2], port_i[5:2]};
                     w_windex_nxt = r_windex + 8'd1;
                     w_wcnt_nxt   = 2'd0;
                  end
               endcase
            end
            ADDR_CRTC_IDX: w_crtc_idx_nxt = port_i[4:0];
            ADDR_CRTC_DAT: begin
               if (r_crtc_idx == CRTC_CUR_HI) begin
                  w_cursor_nxt[11:8] = port_i[3:0];
               end else if (r_crtc_idx == CRTC_CUR_LO) begin
                  w_cursor_nxt[7:0] = port_i;
               end
            end
            ADDR_MODE: w_videomode_nxt = port_i[1];
            default: ;
         endcase
      end

      if (w_rd) begin
         case (port_a)
            ADDR_DAC_DATA: begin
               w_port_o_nxt = {2'b00, w_comp, w_comp[3:2]};
               if (r_rcnt == 2'd2) begin
                  w_rcnt_nxt   = 2'd0;
                  w_rindex_nxt = r_rindex + 8'd1;
               end else begin
                  w_rcnt_nxt = r_rcnt + 2'd1;
               end
            end
            ADDR_CRTC_IDX: w_port_o_nxt = {3'b000, r_crtc_idx};
            ADDR_CRTC_DAT: begin
               if (r_crtc_idx == CRTC_CUR_HI) begin
                  w_port_o_nxt = {4'h0, r_cursor[11:8]};
               end else if (r_crtc_idx == CRTC_CUR_LO) begin
                  w_port_o_nxt = r_cursor[7:0];
               end else begin
                  w_port_o_nxt = 8'h00;
               end
            end
            ADDR_MODE:   w_port_o_nxt = {6'b000000, r_videomode, 1'b0};
            ADDR_STATUS: begin
               w_port_o_nxt = {4'b0000, r_flag, 2'b00, r_flag};
               w_flag_nxt   = 1'b0;
            end
            default: w_port_o_nxt = 8'h00;
         endcase
      end

      // retrace set overrides a coincident status-read clear
      if (vretrace) begin
         w_flag_nxt = 1'b1;
      end

      // palette address follows rindex except during the write pulse
      w_dac_a_nxt = w_dac_w_nxt ? r_windex : w_rindex_nxt;
   end

   // state register with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         r_port_o    <= '0;
         r_videomode <= 1'b0;
         r_cursor    <= '0;
         r_dac_a     <= '0;
         r_dac_d     <= '0;
         r_dac_w     <= 1'b0;
         r_windex    <= '0;
         r_rindex    <= '0;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_red       <= '0;
         r_grn       <= '0;
         r_crtc_idx  <= '0;
         r_flag      <= 1'b0;
      end else begin
         r_port_o    <= w_port_o_nxt;
         r_videomode <= w_videomode_nxt;
         r_cursor    <= w_cursor_nxt;
         r_dac_a     <= w_dac_a_nxt;
         r_dac_d     <= w_dac_d_nxt;
         r_dac_w     <= w_dac_w_nxt;
         r_windex    <= w_windex_nxt;
         r_rindex    <= w_rindex_nxt;
         r_wcnt      <= w_wcnt_nxt;
         r_rcnt      <= w_rcnt_nxt;
         r_red       <= w_red_nxt;
         r_grn       <= w_grn_nxt;
         r_crtc_idx  <= w_crtc_idx_nxt;
         r_flag      <= w_flag_nxt;
      end
   end

   assign port_o    = r_port_o;
   assign videomode = r_videomode;
   assign cursor    = r_cursor;
   assign dac_a     = r_dac_a;
   assign dac_d     = r_dac_d;
   assign dac_w     = r_dac_w;

endmodule

// File: tb/tb_vga_ports.sv
// Directed bench for vga_ports: port table plus palette/retrace/reset sequences.
module tb_vga_ports;

   logic        clock;
   logic        reset;
   logic [15:0] port_a;
   logic [7:0]  port_i;
   logic        port_w;
   logic        port_r;
   logic [7:0]  port_o;
   logic        videomode;
   logic [11:0] cursor;
   logic [7:0]  dac_a;
   logic [11:0] dac_d;
   logic        dac_w;
   logic [11:0] dac_q;
   logic        vretrace;

   int total = 0;
   int bad   = 0;

   logic [11:0] pal [256];
   logic [19:0] evq [$];

   typedef struct {
      logic        w;
      logic        r;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  exp;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   vga_ports dut (
      .clock     (clock),
      .reset     (reset),
      .port_a    (port_a),
      .port_i    (port_i),
      .port_w    (port_w),
      .port_r    (port_r),
      .port_o    (port_o),
      .videomode (videomode),
      .cursor    (cursor),
      .dac_a     (dac_a),
      .dac_d     (dac_d),
      .dac_w     (dac_w),
      .dac_q     (dac_q),
      .vretrace  (vretrace)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // palette RAM model with one-cycle read latency
   always @(posedge clock) dac_q <= pal[dac_a];

   // log every cycle dac_w is high as {dac_a, dac_d}
   always @(negedge clock) begin
      if (dac_w === 1'b1) evq.push_back({dac_a, dac_d});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one-cycle strobe, starting and ending on a falling edge
   task automatic strobe(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
      port_w = w;
      port_r = r;
      port_a = a;
      port_i = d;
      @(negedge clock);
      port_w = 1'b0;
      port_r = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      strobe(1'b1, 1'b0, a, d);
   endtask

   task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
      strobe(1'b0, 1'b1, a, 8'h00);
      chk(name, 32'(port_o), 32'(exp));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) pal[i] = 12'h000;
      pal[8'h20] = 12'hA5C;

      tbl[0]  = '{1'b0, 1'b1, 16'h03D8, 8'h00, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 16'h03D8, 8'h02, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 16'h03D8, 8'h00, 8'h02};
      tbl[3]  = '{1'b1, 1'b0, 16'h03D4, 8'h0E, 8'h02};
      tbl[4]  = '{1'b1, 1'b0, 16'h03D5, 8'h07, 8'h02};
      tbl[5]  = '{1'b1, 1'b0, 16'h03D4, 8'h0F, 8'h02};
      tbl[6]  = '{1'b1, 1'b0, 16'h03D5, 8'hCF, 8'h02};
      tbl[7]  = '{1'b0, 1'b1, 16'h03D5, 8'h00, 8'hCF};
      tbl[8]  = '{1'b0, 1'b1, 16'h03D4, 8'h00, 8'h0F};
      tbl[9]  = '{1'b1, 1'b0, 16'h03D4, 8'h0E, 8'h0F};
      tbl[10] = '{1'b0, 1'b1, 16'h03D5, 8'h00, 8'h07};
      tbl[11] = '{1'b1, 1'b0, 16'h03D4, 8'h03, 8'h07};
      tbl[12] = '{1'b1, 1'b0, 16'h03D5, 8'h55, 8'h07};
      tbl[13] = '{1'b0, 1'b1, 16'h03D5, 8'h00, 8'h00};
      tbl[14] = '{1'b0, 1'b1, 16'h03D4, 8'h00, 8'h03};
      tbl[15] = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'h00};
      tbl[16] = '{1'b1, 1'b0, 16'h03C7, 8'h20, 8'h00};
      tbl[17] = '{1'b0, 1'b1, 16'h03C9, 8'h00, 8'h2A};
      tbl[18] = '{1'b0, 1'b1, 16'h03C9, 8'h00, 8'h15};
      tbl[19] = '{1'b0, 1'b1, 16'h03C9, 8'h00, 8'h33};
      tbl[20] = '{1'b0, 1'b1, 16'h03DA, 8'h00, 8'h00};
      tbl[21] = '{1'b0, 1'b1, 16'h03D4, 8'h00, 8'h03};
      tbl[22] = '{1'b1, 1'b1, 16'h03D8, 8'h00, 8'h03};
      tbl[23] = '{1'b0, 1'b1, 16'h03D8, 8'h00, 8'h00};

      reset    = 1'b1;
      port_a   = 16'h0000;
      port_i   = 8'h00;
      port_w   = 1'b0;
      port_r   = 1'b0;
      vretrace = 1'b0;
      idle(3);
      chk("rst_port_o", 32'(port_o), 32'h0);
      chk("rst_videomode", 32'(videomode), 32'h0);
      chk("rst_cursor", 32'(cursor), 32'h0);
      chk("rst_dac_a", 32'(dac_a), 32'h0);
      chk("rst_dac_w", 32'(dac_w), 32'h0);
      reset = 1'b0;
      idle(1);

      // table: each op followed by one idle cycle; port_o checked after every op
      for (int i = 0; i < NV; i++) begin
         strobe(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
         chk($sformatf("tbl%0d_port_o", i), 32'(port_o), 32'(tbl[i].exp));
         idle(1);
      end
      chk("cursor_7cf", 32'(cursor), 32'h7CF);
      chk("videomode_cleared", 32'(videomode), 32'h0);
      chk("dac_a_rindex_21", 32'(dac_a), 32'h21);
      chk("no_spurious_dac_w", 32'(evq.size()), 32'd0);

      // palette write of one triple, then a second triple at the incremented index
      evq.delete();
      wr(16'h03C8, 8'h10);
      wr(16'h03C9, 8'h3F);
      wr(16'h03C9, 8'h20);
      wr(16'h03C9, 8'h04);
      idle(3);
      chk("pw_count", 32'(evq.size()), 32'd1);
      if (evq.size() >= 1) chk("pw_ev0", 32'(evq[0]), 32'h10F81);
      chk("pw_dac_a_back", 32'(dac_a), 32'h21);
      evq.delete();
      wr(16'h03C9, 8'h3C);
      wr(16'h03C9, 8'h3C);
      wr(16'h03C9, 8'h3C);
      idle(3);
      chk("pw2_count", 32'(evq.size()), 32'd1);
      if (evq.size() >= 1) chk("pw2_ev0", 32'(evq[0]), 32'h11FFF);

      // index wrap FFh -> 00h
      evq.delete();
      wr(16'h03C8, 8'hFF);
      wr(16'h03C9, 8'h3F);
      wr(16'h03C9, 8'h00);
      wr(16'h03C9, 8'h00);
      wr(16'h03C9, 8'h00);
      wr(16'h03C9, 8'h00);
      wr(16'h03C9, 8'h3F);
      idle(3);
      chk("wrap_count", 32'(evq.size()), 32'd2);
      if (evq.size() >= 2) begin
         chk("wrap_ev0", 32'(evq[0]), 32'hFFF00);
         chk("wrap_ev1", 32'(evq[1]), 32'h0000F);
      end

      // aborted partial triple
      evq.delete();
      wr(16'h03C8, 8'h05);
      wr(16'h03C9, 8'h01);
      wr(16'h03C9, 8'h02);
      wr(16'h03C8, 8'h07);
      wr(16'h03C9, 8'h04);
      wr(16'h03C9, 8'h08);
      wr(16'h03C9, 8'h0C);
      idle(3);
      chk("abort_count", 32'(evq.size()), 32'd1);
      if (evq.size() >= 1) chk("abort_ev0", 32'(evq[0]), 32'h07123);

      // retrace flag set/clear and coincident-read cases
      vretrace = 1'b1;
      idle(1);
      vretrace = 1'b0;
      rd_chk("rt_set", 16'h03DA, 8'h09);
      rd_chk("rt_cleared", 16'h03DA, 8'h00);
      vretrace = 1'b1;
      rd_chk("rt_coinc_pre0", 16'h03DA, 8'h00);
      vretrace = 1'b0;
      rd_chk("rt_coinc_set", 16'h03DA, 8'h09);
      vretrace = 1'b1;
      idle(1);
      rd_chk("rt_coinc_pre1", 16'h03DA, 8'h09);
      vretrace = 1'b0;
      rd_chk("rt_set_wins", 16'h03DA, 8'h09);
      rd_chk("rt_final_clear", 16'h03DA, 8'h00);
      idle(1);
      chk("port_o_holds", 32'(port_o), 32'h00);

      // reset mid-triple, colliding with a third data write
      wr(16'h03D8, 8'h02);
      wr(16'h03D4, 8'h0F);
      wr(16'h03D5, 8'hAB);
      rd_chk("pre_rst_idx", 16'h03D4, 8'h0F);
      evq.delete();
      wr(16'h03C8, 8'h30);
      wr(16'h03C9, 8'h3F);
      wr(16'h03C9, 8'h3F);
      reset  = 1'b1;
      port_w = 1'b1;
      port_a = 16'h03C9;
      port_i = 8'h3F;
      idle(1);
      port_w = 1'b0;
      chk("mid_rst_port_o", 32'(port_o), 32'h0);
      chk("mid_rst_videomode", 32'(videomode), 32'h0);
      chk("mid_rst_cursor", 32'(cursor), 32'h0);
      chk("mid_rst_dac_a", 32'(dac_a), 32'h0);
      chk("mid_rst_dac_w", 32'(dac_w), 32'h0);
      idle(1);
      reset = 1'b0;
      idle(2);
      chk("mid_rst_no_write", 32'(evq.size()), 32'd0);
      wr(16'h03C9, 8'h3F);
      idle(2);
      chk("post_rst_partial", 32'(evq.size()), 32'd0);
      wr(16'h03C9, 8'h3F);
      wr(16'h03C9, 8'h3F);
      idle(3);
      chk("post_rst_count", 32'(evq.size()), 32'd1);
      if (evq.size() >= 1) chk("post_rst_ev0", 32'(evq[0]), 32'h00FFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
